// File: rtl/imm_extend_unit_pkg.sv
// Shared types for the immediate-extension stage.
// Holds the immediate mode encoding used on the decode interface and the
// encoding of the two-state prefix tracker kept by the top level.
package imm_extend_unit_pkg;

  // Immediate interpretation selected by decode alongside the raw field.
  typedef enum logic [1:0] {
    IMM_ZERO   = 2'b00,
    IMM_SIGN   = 2'b01,
    IMM_BRANCH = 2'b10,
    IMM_PREFIX = 2'b11
  } imm_mode_t;

  // Whether an upper-byte prefix is waiting for the next immediate.
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_PREFIXED = 1'b1
  } prefix_state_t;

endpackage

// File: rtl/imm_extend_unit_core.sv
// Combinational extension datapath.
// Turns an IN_W-bit immediate into an OUT_W-bit operand according to the
// mode, or splices it under a previously captured prefix.
// Ports:
//   imm_i            raw immediate field
//   mode_i           ZERO / SIGN / BRANCH / PREFIX
//   prefix_i         captured upper immediate
//   prefix_pending_i prefix_i is valid and overrides the mode
//   result_o         extended operand
module imm_extend_core
  import imm_extend_unit_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  imm_i,
  input  imm_mode_t        mode_i,
  input  logic [IN_W-1:0]  prefix_i,
  input  logic             prefix_pending_i,
  output logic [OUT_W-1:0] result_o
);

  logic [OUT_W-1:0]  zeroExt;
  logic [OUT_W-1:0]  signExt;
  logic [2*IN_W-1:0] joined;

  assign zeroExt = {{(OUT_W-IN_W){1'b0}}, imm_i};
  assign signExt = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
  assign joined  = {prefix_i, imm_i};

  // A pending prefix wins over the mode; otherwise the mode picks the
  // extension. The branch form drops the sign-extended MSB when shifting.
  // PREFIX never reaches the output register, so its arm is a don't-care.
  always_comb begin
    result_o = '0;
    if (prefix_pending_i) begin
      result_o = joined[OUT_W-1:0];
    end else begin
      case (mode_i)
        IMM_ZERO:   result_o = zeroExt;
        IMM_SIGN:   result_o = signExt;
        IMM_BRANCH: result_o = {signExt[OUT_W-2:0], 1'b0};
        default:    result_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Registered immediate-extension stage between decode and the ALU operand mux.
// One-entry output buffer with valid/ready on both sides and a prefix
// mechanism for building full-width constants from two beats.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   flush           synchronous clear of pending prefix and output register
//   in_valid/ready  input handshake for imm_in + mode
//   imm_in, mode    raw immediate field and its interpretation
//   out_valid/ready output handshake for imm_out
//   imm_out         extended operand
//   prefix_pending  a prefix has been captured and not yet consumed
module imm_extend_unit
  import imm_extend_unit_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out,
  output logic             prefix_pending
);

  if (!((IN_W < OUT_W) && (OUT_W <= 2*IN_W))) begin : gIllegalWidths
    $error("imm_extend_unit: need IN_W < OUT_W <= 2*IN_W");
  end

  prefix_state_t    state_q, state_d;
  logic [IN_W-1:0]  prefix_q, prefix_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             accept;
  logic             isPrefix;
  imm_mode_t        modeSel;
  logic [OUT_W-1:0] coreResult;

  assign modeSel        = imm_mode_t'(mode);
  assign isPrefix       = (modeSel == IMM_PREFIX);
  assign in_ready       = !flush && (!valid_q || out_ready);
  assign accept         = in_valid && in_ready;
  assign out_valid      = valid_q;
  assign imm_out        = data_q;
  assign prefix_pending = (state_q == ST_PREFIXED);

  imm_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm_i            (imm_in),
    .mode_i           (modeSel),
    .prefix_i         (prefix_q),
    .prefix_pending_i (prefix_pending),
    .result_o         (coreResult)
  );

  // Prefix tracker: a PREFIX beat arms it (or re-arms with a new value),
  // any other accepted beat consumes it, and flush discards it.
  always_comb begin
    state_d  = state_q;
    prefix_d = prefix_q;
    if (flush) begin
      state_d  = ST_IDLE;
      prefix_d = '0;
    end else if (accept) begin
      if (isPrefix) begin
        state_d  = ST_PREFIXED;
        prefix_d = imm_in;
      end else begin
        state_d  = ST_IDLE;
      end
    end
  end

  // Output buffer: flush beats everything, a new non-prefix beat replaces
  // the current result (even while it is being drained), otherwise a
  // completed drain empties the buffer and a stalled one holds it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept && !isPrefix) begin
      valid_d = 1'b1;
      data_d  = coreResult;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // All state registers share the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      prefix_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      prefix_q <= prefix_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit (IN_W=8, OUT_W=16).
// Expected results are pushed when a beat is accepted; a monitor pops and
// compares whenever the DUT presents a result.
module tb_imm_extend_unit;

  localparam logic [1:0] M_ZERO   = 2'd0;
  localparam logic [1:0] M_SIGN   = 2'd1;
  localparam logic [1:0] M_BRANCH = 2'd2;
  localparam logic [1:0] M_PREFIX = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  imm_in = '0;
  logic [1:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] imm_out;
  logic        prefix_pending;

  int          total = 0;
  int          bad = 0;
  logic [15:0] expQ[$];
  bit          pendingM = 0;
  int          preM = 0;
  bit          randOn = 0;

  imm_extend_unit #(.IN_W(8), .OUT_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .imm_in         (imm_in),
    .mode           (mode),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .imm_out        (imm_out),
    .prefix_pending (prefix_pending)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: operand value as an integer, reduced mod 2^16.
  function automatic logic [15:0] refResult(input logic [1:0] m, input int d,
                                            input bit pend, input int pre);
    int s;
    int r;
    s = (d >= 128) ? d - 256 : d;
    if (pend)               r = pre * 256 + d;
    else if (m == M_ZERO)   r = d;
    else if (m == M_SIGN)   r = s;
    else                    r = s * 2;
    r = r % 65536;
    if (r < 0) r = r + 65536;
    return 16'(r);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] d);
    int  waited = 0;
    bit  taken = 0;
    mode = m;
    imm_in = d;
    in_valid = 1'b1;
    while (!taken && waited < 50) begin
      @(negedge clk);
      if (in_ready) begin
        taken = 1;
        if (m == M_PREFIX) begin
          pendingM = 1;
          preM = int'(d);
        end else begin
          expQ.push_back(refResult(m, int'(d), pendingM, preM));
          pendingM = 0;
        end
      end else begin
        waited++;
      end
    end
    if (!taken) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
    @(posedge clk);
    #1;
    checkOutput("prefix_pending", 32'(prefix_pending), 32'(pendingM));
  endtask

  task automatic idleInputs();
    in_valid = 1'b0;
  endtask

  task automatic waitEmpty();
    int n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", expQ.size());
    end
  endtask

  // Monitor: a presented result must match the oldest expected value; it is
  // retired when the consumer is ready and must be held while it is not.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_out: got 0x%0h expected no output", imm_out);
      end else if (out_ready) begin
        checkOutput("imm_out", 32'(imm_out), 32'(expQ.pop_front()));
      end else begin
        checkOutput("imm_out_hold", 32'(imm_out), 32'(expQ[0]));
      end
    end
  end

  // Random consumer backpressure during the random phase.
  always @(posedge clk) begin
    if (randOn) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_imm_out", 32'(imm_out), 32'd0);
    checkOutput("reset_prefix_pending", 32'(prefix_pending), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back extensions in every non-prefix mode.
    applyStimulus(M_SIGN, 8'hFF);
    applyStimulus(M_SIGN, 8'h7F);
    applyStimulus(M_ZERO, 8'hFF);
    applyStimulus(M_BRANCH, 8'h80);
    applyStimulus(M_BRANCH, 8'h7F);
    // Prefix then sign beat builds 0x1284; double prefix keeps the last.
    applyStimulus(M_PREFIX, 8'h12);
    applyStimulus(M_SIGN, 8'h84);
    applyStimulus(M_PREFIX, 8'h12);
    applyStimulus(M_PREFIX, 8'h34);
    applyStimulus(M_ZERO, 8'h56);
    idleInputs();
    waitEmpty();

    // Backpressure: 0x00AB held for 3 cycles while the next beat waits.
    out_ready = 1'b0;
    applyStimulus(M_ZERO, 8'hAB);
    fork
      applyStimulus(M_SIGN, 8'h80);
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
          checkOutput("bp_imm_out", 32'(imm_out), 32'h00AB);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idleInputs();
    waitEmpty();

    // Flush with a pending prefix and a coincident beat that must be dropped.
    applyStimulus(M_PREFIX, 8'h12);
    flush = 1'b1;
    mode = M_SIGN;
    imm_in = 8'h01;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    pendingM = 0;
    preM = 0;
    checkOutput("flush_prefix_pending", 32'(prefix_pending), 32'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(M_ZERO, 8'h05);
    idleInputs();
    waitEmpty();

    // Randomised traffic with random consumer stalls.
    randOn = 1;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) begin
        idleInputs();
        @(posedge clk);
        #1;
      end
    end
    idleInputs();
    randOn = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    waitEmpty();

    // Asynchronous reset in the middle of backpressure.
    out_ready = 1'b0;
    applyStimulus(M_ZERO, 8'hAB);
    idleInputs();
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    expQ.delete();
    pendingM = 0;
    preM = 0;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_imm_out", 32'(imm_out), 32'd0);
    checkOutput("async_prefix_pending", 32'(prefix_pending), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    applyStimulus(M_SIGN, 8'h7F);
    idleInputs();
    waitEmpty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

Parametrised, registered immediate-extension stage for the 16-bit processor datapath. It sits between instruction decode and the ALU operand mux. It accepts an IN_W-bit immediate field plus a mode and produces an OUT_W-bit operand. Supported modes are zero-extend, sign-extend and a branch-offset form (sign-extend, then shift left 1). A prefix mode captures an upper byte so that the next immediate forms a full-width constant. Valid/ready handshakes are used on both sides.

## Interface
Parameters:
- IN_W, default 8: immediate field width.
- OUT_W, default 16: output operand width. Legal range is IN_W < OUT_W <= 2*IN_W; a legal-range assertion fires at elaboration.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous clear of the pending prefix and the output register.
- in_valid, input, 1: the immediate and mode are presented.
- in_ready, output, 1: the unit can accept a beat.
- imm_in, input, IN_W: raw immediate field.
- mode, input, 2: 00 ZERO, 01 SIGN, 10 BRANCH, 11 PREFIX.
- out_valid, output, 1: imm_out holds a result.
- out_ready, input, 1: the consumer accepts the result.
- imm_out, output, OUT_W: extended operand.
- prefix_pending, output, 1: a prefix has been captured and not yet consumed.

## Operation
- Accept: a beat is accepted when in_valid && in_ready.
- Handshake logic: in_ready = !flush && (!out_valid || out_ready), so the unit is a one-entry buffer with full throughput.
- Result computation for a non-prefix beat, with prefix_pending=0:
  - ZERO: imm_out = zero-extend(imm_in).
  - SIGN: imm_out = replicate imm_in[IN_W-1] into bits OUT_W-1..IN_W.
  - BRANCH: imm_out = (sign-extended value << 1), truncated to OUT_W; the MSB is dropped.
- Prefix handling:
  - A PREFIX beat loads the prefix register, sets prefix_pending and produces no output.
  - A second PREFIX beat while one is pending overwrites the first.
- Non-prefix beat with prefix_pending=1: mode is ignored. imm_out = low OUT_W bits of {prefix, imm_in}, and prefix_pending clears on the same edge.
- Prefix state machine, two states:
  - IDLE → PREFIXED on an accepted PREFIX beat.
  - PREFIXED → IDLE on an accepted non-prefix beat, or on flush.
  - PREFIXED → PREFIXED on an accepted PREFIX beat.
- Output register:
  - Loads on accept of a non-prefix beat.
  - out_valid clears when out_valid && out_ready and no new beat is loaded.
  - out_valid and imm_out are held stable while out_ready=0.
- Flush:
  - On the next edge, out_valid=0 and prefix_pending=0.
  - in_ready is 0 while flush is high, so a coincident input beat is dropped.
  - Flush overrides both accept and drain.
- Reset values: out_valid=0, imm_out=0, prefix_pending=0, prefix register=0, state IDLE. in_ready=1 once reset deasserts.

## Timing
- Latency: a non-prefix beat accepted at edge N gives out_valid=1 with the result after edge N.
- A PREFIX beat adds no output cycle; the combined result appears one cycle after the following beat is accepted.
- Throughput is one result per cycle when out_ready is held at 1.
- Output registers are not combinationally dependent on imm_in; in_ready depends combinationally on out_ready and flush only.
- Simultaneous drain and accept: the new result replaces the old one on the same edge, and out_valid stays 1.
- Reset asserted mid-operation clears all state immediately, without waiting for clk; a pending prefix or undelivered result is discarded.

## Structure
- A shared package holds:
  - the imm_mode_t enum (ZERO, SIGN, BRANCH, PREFIX);
  - the prefix-state enum (IDLE, PREFIXED).
- One natural combinational sub-module, imm_extend_core: computes the OUT_W result from imm_in, mode, prefix and prefix_pending. It generalises the fixed 8-to-16 sign extender.
- The top level holds the prefix register, the state register, the output register and the handshake logic.

## Test plan
All scenarios use IN_W=8, OUT_W=16, with out_ready=1 unless stated.
- SIGN 0xFF → imm_out 0xFFFF; SIGN 0x7F → 0x007F; each valid one cycle after accept, back-to-back, out_valid continuously 1.
- ZERO 0xFF → 0x00FF; BRANCH 0x80 → 0xFF00; BRANCH 0x7F → 0x00FE.
- PREFIX 0x12, then SIGN 0x84:
  - after the PREFIX beat, no output and prefix_pending=1;
  - after the SIGN beat, imm_out 0x1284 and prefix_pending=0.
- Two PREFIX beats (0x12 then 0x34), then ZERO 0x56 → 0x3456.
- Backpressure: result 0x00AB with out_ready=0 for 3 cycles → imm_out held at 0x00AB and in_ready=0; after out_ready=1 the next queued beat appears the following cycle.
- Flush with a PREFIX 0x12 pending and coincident in_valid (SIGN 0x01):
  - the SIGN 0x01 beat is dropped and prefix_pending=0;
  - a next ZERO 0x05 gives 0x0005.
  - Separately, reset asserted asynchronously mid-backpressure → out_valid and imm_out go to 0 before the next clk edge.
